// File: rtl/oisc8_ram_arbiter_if.sv
// Bus bundle shared by the two requesters, the RAM port and the arbiter.
// The "slave" modport is the arbiter's view; "master" is the environment
// (requesters plus RAM) driving it.
interface oisc8_ram_arbiter_if #(
    parameter int AW = 24,
    parameter int DW = 16
);
    logic [1:0]      m_req;
    logic [1:0]      m_we;
    logic [2*AW-1:0] m_addr;
    logic [2*DW-1:0] m_wdata;
    logic [1:0]      m_gnt;
    logic [1:0]      m_rvalid;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_err;
    logic            ram_req;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic            ram_ready;
    logic            ram_rvalid;
    logic [DW-1:0]   ram_rdata;

    modport slave (
        input  m_req, m_we, m_addr, m_wdata,
        output m_gnt, m_rvalid, m_rdata, m_err,
        output ram_req, ram_we, ram_addr, ram_wdata,
        input  ram_ready, ram_rvalid, ram_rdata
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata,
        input  m_gnt, m_rvalid, m_rdata, m_err,
        input  ram_req, ram_we, ram_addr, ram_wdata,
        output ram_ready, ram_rvalid, ram_rdata
    );
endinterface

// File: rtl/oisc8_ram_arbiter.sv
// Two-master arbiter for the single external RAM port.
// M0 (CPU) has fixed priority; M1 (DMA) is forced through after M0 has won
// STARVE_LIMIT times in a row while M1 was waiting. Only one transaction is
// in flight; a read that never returns data is closed after TIMEOUT cycles
// with zero data and an error pulse.
module oisc8_ram_arbiter #(
    parameter int AW           = 24,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    oisc8_ram_arbiter_if.slave    bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX   = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

    state_t        state;
    logic [SW-1:0] streak;
    logic [TW-1:0] wait_cnt;
    logic          owner;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [1:0]    rvalid_q;
    logic [1:0]    err_q;
    logic [DW-1:0] rdata_q;
    logic          pick_m1;
    logic [1:0]    owner_onehot;

    // Winner for the current IDLE cycle: M1 only if M0 is quiet or M1 has waited out its streak
    always_comb begin
        pick_m1      = bus.m_req[1] & (~bus.m_req[0] | (streak == STREAK_MAX));
        owner_onehot = owner ? 2'b10 : 2'b01;
    end

    // Main controller: command capture, RAM handshake, read completion and timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            streak    <= '0;
            wait_cnt  <= '0;
            owner     <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rvalid_q  <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
        end else begin
            rvalid_q <= '0;
            err_q    <= '0;
            case (state)
                IDLE: begin
                    if (|bus.m_req) begin
                        owner     <= pick_m1;
                        cmd_we    <= bus.m_we[pick_m1];
                        cmd_addr  <= pick_m1 ? bus.m_addr[AW +: AW] : bus.m_addr[0 +: AW];
                        cmd_wdata <= pick_m1 ? bus.m_wdata[DW +: DW] : bus.m_wdata[0 +: DW];
                        state     <= ISSUE;
                    end
                    // M0 can only win here while streak is below the limit, so the increment never wraps
                    if (!bus.m_req[1] || pick_m1) begin
                        streak <= '0;
                    end else begin
                        streak <= streak + 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.ram_ready) begin
                        if (cmd_we) begin
                            state <= IDLE;
                        end else begin
                            state    <= RD_WAIT;
                            wait_cnt <= '0;
                        end
                    end
                end
                RD_WAIT: begin
                    if (bus.ram_rvalid) begin
                        rvalid_q <= owner_onehot;
                        rdata_q  <= bus.ram_rdata;
                        state    <= IDLE;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        rvalid_q <= owner_onehot;
                        err_q    <= owner_onehot;
                        rdata_q  <= '0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM command comes straight from the captured registers; grant is the same-cycle accept
    always_comb begin
        bus.ram_req   = (state == ISSUE);
        bus.ram_we    = cmd_we;
        bus.ram_addr  = cmd_addr;
        bus.ram_wdata = cmd_wdata;
        bus.m_gnt     = ((state == ISSUE) && bus.ram_ready) ? owner_onehot : 2'b00;
        bus.m_rvalid  = rvalid_q;
        bus.m_err     = err_q;
        bus.m_rdata   = rdata_q;
    end
endmodule

// File: tb/tb_oisc8_ram_arbiter.sv
// Testbench for oisc8_ram_arbiter: table of single transactions, directed
// multi-cycle sequences, then randomized traffic against a schedule model.
module tb_oisc8_ram_arbiter;
    localparam int AW      = 24;
    localparam int DW      = 16;
    localparam int STARVE  = 4;
    localparam int TIMEOUT = 8;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   cyc;
    logic [15:0] last_rdata;

    oisc8_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    oisc8_ram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(STARVE), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          m;
        int          we;
        logic [23:0] addr;
        logic [15:0] wdata;
        int          ready_dly;
        int          rsp_dly;
        logic [15:0] rsp_data;
        logic [1:0]  exp_gnt;
        logic [1:0]  exp_rvalid;
        logic [1:0]  exp_err;
        logic [15:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t tbl [7];

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.m_req      = '0;
        bus.m_we       = '0;
        bus.ram_ready  = 1'b0;
        bus.ram_rvalid = 1'b0;
        bus.ram_rdata  = '0;
    endtask

    task automatic set_cmd(input int i, input int we, input logic [23:0] addr, input logic [15:0] wdata);
        bus.m_req[i]               = 1'b1;
        bus.m_we[i]                = (we != 0);
        bus.m_addr[i*AW +: AW]     = addr;
        bus.m_wdata[i*DW +: DW]    = wdata;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_m_gnt"}, 32'(bus.m_gnt), 32'h0);
        check_output({tag, "_m_rvalid"}, 32'(bus.m_rvalid), 32'h0);
        check_output({tag, "_m_err"}, 32'(bus.m_err), 32'h0);
        check_output({tag, "_m_rdata"}, 32'(bus.m_rdata), 32'h0);
        check_output({tag, "_ram_req"}, 32'(bus.ram_req), 32'h0);
        check_output({tag, "_ram_we"}, 32'(bus.ram_we), 32'h0);
        check_output({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'h0);
        check_output({tag, "_ram_wdata"}, 32'(bus.ram_wdata), 32'h0);
    endtask

    // One complete transaction from a table record, starting in an IDLE cycle
    task automatic apply_stimulus(input vec_t v);
        next_cycle();
        idle_inputs();
        set_cmd(v.m, v.we, v.addr, v.wdata);
        settle();
        check_output("tbl_rdata_hold", 32'(bus.m_rdata), 32'(last_rdata));
        check_output("tbl_idle_ram_req", 32'(bus.ram_req), 32'h0);
        for (int k = 0; k <= v.ready_dly; k++) begin
            next_cycle();
            bus.ram_ready = (k == v.ready_dly);
            settle();
            check_output("tbl_ram_req", 32'(bus.ram_req), 32'h1);
            check_output("tbl_ram_addr", 32'(bus.ram_addr), 32'(v.addr));
            check_output("tbl_ram_we", 32'(bus.ram_we), 32'(v.we));
            if (v.we != 0) check_output("tbl_ram_wdata", 32'(bus.ram_wdata), 32'(v.wdata));
            check_output("tbl_m_gnt", 32'(bus.m_gnt), (k == v.ready_dly) ? 32'(v.exp_gnt) : 32'h0);
        end
        for (int k = 1; k <= v.exp_lat; k++) begin
            next_cycle();
            idle_inputs();
            bus.ram_rvalid = (k == v.rsp_dly);
            bus.ram_rdata  = (k == v.rsp_dly) ? v.rsp_data : 16'h0;
            settle();
            check_output("tbl_rd_ram_req", 32'(bus.ram_req), 32'h0);
            check_output("tbl_m_rvalid", 32'(bus.m_rvalid), (k == v.exp_lat) ? 32'(v.exp_rvalid) : 32'h0);
            check_output("tbl_m_err", 32'(bus.m_err), (k == v.exp_lat) ? 32'(v.exp_err) : 32'h0);
            if (k == v.exp_lat) begin
                check_output("tbl_m_rdata", 32'(bus.m_rdata), 32'(v.exp_rdata));
                last_rdata = v.exp_rdata;
            end
        end
    endtask

    // Randomized traffic checked against a transaction schedule derived from the arbitration rules
    task automatic run_random(input int ncycles);
        bit          pend [2];
        bit          we_p [2];
        logic [23:0] addr_p [2];
        logic [15:0] wdata_p [2];
        int          next_idle, t_issue, t_gnt, t_rsp, t_done, streak, r;
        bit          issuing, reading, rd_err, own, own_we, win;
        logic [23:0] own_addr;
        logic [15:0] own_wdata, rsp_data;
        logic [1:0]  e_gnt, e_rv, e_err;
        bit          e_req;
        pend[0] = 0; pend[1] = 0;
        we_p[0] = 0; we_p[1] = 0;
        addr_p[0] = '0; addr_p[1] = '0;
        wdata_p[0] = '0; wdata_p[1] = '0;
        streak = 0; issuing = 0; reading = 0; rd_err = 0; own = 0; own_we = 0;
        next_idle = 0; t_issue = 0; t_gnt = 0; t_rsp = -1; t_done = -1;
        own_addr = '0; own_wdata = '0; rsp_data = '0;
        for (int c = 0; c < ncycles; c++) begin
            next_cycle();
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]    = 1;
                    we_p[i]    = 1'($urandom_range(0, 1));
                    addr_p[i]  = 24'($urandom);
                    wdata_p[i] = 16'($urandom);
                end
                bus.m_req[i]            = pend[i];
                bus.m_we[i]             = we_p[i];
                bus.m_addr[i*AW +: AW]  = addr_p[i];
                bus.m_wdata[i*DW +: DW] = wdata_p[i];
            end
            bus.ram_ready  = 1'($urandom_range(0, 1));
            bus.ram_rvalid = 1'($urandom_range(0, 1));
            bus.ram_rdata  = 16'($urandom);
            e_gnt = '0; e_rv = '0; e_err = '0; e_req = 0;
            if (reading && c == t_done) begin
                e_rv       = own ? 2'b10 : 2'b01;
                e_err      = rd_err ? e_rv : 2'b00;
                last_rdata = rd_err ? 16'h0 : rsp_data;
                reading    = 0;
            end else if (reading) begin
                bus.ram_rvalid = (c == t_rsp);
                if (c == t_rsp) bus.ram_rdata = rsp_data;
            end
            if (c == next_idle) begin
                win = pend[1] && (!pend[0] || streak == STARVE);
                if (!pend[1] || win) streak = 0;
                else streak++;
                if (pend[0] || pend[1]) begin
                    own       = win;
                    own_we    = we_p[win];
                    own_addr  = addr_p[win];
                    own_wdata = wdata_p[win];
                    issuing   = 1;
                    t_issue   = c + 1;
                    t_gnt     = c + 1 + $urandom_range(0, 3);
                    next_idle = -1;
                end else begin
                    next_idle = c + 1;
                end
            end else if (issuing && c >= t_issue) begin
                e_req         = 1;
                bus.ram_ready = (c == t_gnt);
                if (c == t_gnt) begin
                    e_gnt   = own ? 2'b10 : 2'b01;
                    issuing = 0;
                    if (own_we) begin
                        next_idle = c + 1;
                    end else begin
                        r        = $urandom_range(1, TIMEOUT + 2);
                        reading  = 1;
                        rsp_data = 16'($urandom);
                        if (r <= TIMEOUT) begin
                            rd_err = 0; t_rsp = c + r; t_done = c + r + 1;
                        end else begin
                            rd_err = 1; t_rsp = -1; t_done = c + TIMEOUT + 1;
                        end
                        next_idle = t_done;
                    end
                end
            end
            settle();
            check_output("rnd_ram_req", 32'(bus.ram_req), 32'(e_req));
            check_output("rnd_m_gnt", 32'(bus.m_gnt), 32'(e_gnt));
            check_output("rnd_m_rvalid", 32'(bus.m_rvalid), 32'(e_rv));
            check_output("rnd_m_err", 32'(bus.m_err), 32'(e_err));
            check_output("rnd_m_rdata", 32'(bus.m_rdata), 32'(last_rdata));
            if (e_req) begin
                check_output("rnd_ram_addr", 32'(bus.ram_addr), 32'(own_addr));
                check_output("rnd_ram_we", 32'(bus.ram_we), 32'(own_we));
                if (own_we) check_output("rnd_ram_wdata", 32'(bus.ram_wdata), 32'(own_wdata));
            end
            if (e_gnt != 2'b00) pend[own] = 0;
        end
    endtask

    // Test sequence
    initial begin
        int order [10];
        errors = 0; checks = 0; cyc = 0; last_rdata = '0;
        order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        tbl[0] = '{0, 1, 24'h000010, 16'hBEEF, 0, -1, 16'h0000, 2'b01, 2'b00, 2'b00, 16'h0000, 0};
        tbl[1] = '{1, 0, 24'hFF0FFE, 16'h0000, 0,  3, 16'h1234, 2'b10, 2'b10, 2'b00, 16'h1234, 4};
        tbl[2] = '{0, 0, 24'h000100, 16'h0000, 0, -1, 16'h0000, 2'b01, 2'b01, 2'b01, 16'h0000, 9};
        tbl[3] = '{0, 0, 24'h123456, 16'h0000, 1,  1, 16'hA5A5, 2'b01, 2'b01, 2'b00, 16'hA5A5, 2};
        tbl[4] = '{1, 1, 24'hABCDEF, 16'h5555, 2, -1, 16'h0000, 2'b10, 2'b00, 2'b00, 16'h0000, 0};
        tbl[5] = '{1, 0, 24'h000001, 16'h0000, 0,  8, 16'h7E7E, 2'b10, 2'b10, 2'b00, 16'h7E7E, 9};
        tbl[6] = '{0, 0, 24'h00F00F, 16'h0000, 0,  1, 16'h0F0F, 2'b01, 2'b01, 2'b00, 16'h0F0F, 2};

        rst = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        idle_inputs();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 7; i++) apply_stimulus(tbl[i]);

        $display("[TB] starvation guard");
        next_cycle();
        idle_inputs();
        set_cmd(0, 1, 24'h000A00, 16'h0A0A);
        set_cmd(1, 1, 24'h000B00, 16'h0B0B);
        bus.ram_ready = 1'b1;
        settle();
        check_output("starve_idle_ram_req", 32'(bus.ram_req), 32'h0);
        for (int g = 0; g < 10; g++) begin
            next_cycle();
            settle();
            check_output("starve_gnt", 32'(bus.m_gnt), (order[g] == 1) ? 32'h2 : 32'h1);
            check_output("starve_addr", 32'(bus.ram_addr), (order[g] == 1) ? 32'h000B00 : 32'h000A00);
            next_cycle();
            settle();
            check_output("starve_bubble_gnt", 32'(bus.m_gnt), 32'h0);
        end
        next_cycle();
        idle_inputs();
        bus.ram_ready = 1'b1;
        settle();
        check_output("starve_tail_gnt", 32'(bus.m_gnt), 32'h1);
        next_cycle();
        idle_inputs();
        settle();

        $display("[TB] ready stall with changing master command");
        next_cycle();
        set_cmd(0, 1, 24'h00AAAA, 16'h1111);
        settle();
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            bus.ram_ready = 1'b0;
            if (k == 0) set_cmd(0, 0, 24'h0BBBBB, 16'h2222);
            if (k == 2) bus.m_req = '0;
            settle();
            check_output("stall_ram_req", 32'(bus.ram_req), 32'h1);
            check_output("stall_ram_addr", 32'(bus.ram_addr), 32'h00AAAA);
            check_output("stall_ram_wdata", 32'(bus.ram_wdata), 32'h1111);
            check_output("stall_ram_we", 32'(bus.ram_we), 32'h1);
            check_output("stall_m_gnt", 32'(bus.m_gnt), 32'h0);
        end
        next_cycle();
        bus.ram_ready = 1'b1;
        settle();
        check_output("stall_release_gnt", 32'(bus.m_gnt), 32'h1);
        check_output("stall_release_addr", 32'(bus.ram_addr), 32'h00AAAA);
        next_cycle();
        idle_inputs();
        settle();
        check_output("stall_done_ram_req", 32'(bus.ram_req), 32'h0);

        $display("[TB] reset during read wait");
        next_cycle();
        set_cmd(0, 0, 24'h000444, 16'h0000);
        settle();
        next_cycle();
        bus.ram_ready = 1'b1;
        settle();
        check_output("rst_rd_gnt", 32'(bus.m_gnt), 32'h1);
        next_cycle();
        idle_inputs();
        settle();
        next_cycle();
        settle();
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        next_cycle();
        next_cycle();
        @(negedge clk);
        rst = 1'b1;
        last_rdata = '0;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            bus.ram_rvalid = (k < 2);
            bus.ram_rdata  = 16'hDEAD;
            settle();
            check_output("post_rst_m_rvalid", 32'(bus.m_rvalid), 32'h0);
            check_output("post_rst_m_err", 32'(bus.m_err), 32'h0);
            check_output("post_rst_m_rdata", 32'(bus.m_rdata), 32'h0);
            check_output("post_rst_ram_req", 32'(bus.ram_req), 32'h0);
        end
        next_cycle();
        idle_inputs();
        set_cmd(1, 1, 24'h000555, 16'h5A5A);
        bus.ram_ready = 1'b1;
        settle();
        next_cycle();
        settle();
        check_output("post_rst_serve_req", 32'(bus.ram_req), 32'h1);
        check_output("post_rst_serve_gnt", 32'(bus.m_gnt), 32'h2);
        next_cycle();
        idle_inputs();
        settle();

        $display("[TB] randomized traffic");
        run_random(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
